wb_arbiter: RTL and testbench

//  Shares the general register file's single write-back port (wb_i/wb_r_i/result_i) among N_REQ result producers.

---
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register file's single write-back port among
// N_REQ result producers. A round-robin pointer picks the next producer,
// and a per-requester wait counter gives absolute priority to any producer
// that has waited MAX_WAIT cycles. The granted result is registered and
// presented to the register file exactly one cycle after the transfer.
module wb_arbiter #(
  parameter int N_REQ    = 3,
  parameter int W_RD     = 4,
  parameter int W_OPR    = 16,
  parameter int MAX_WAIT = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*W_RD-1:0]  req_rd_i,
  input  logic [N_REQ*W_OPR-1:0] req_data_i,
  input  logic                   flush_i,
  output logic                   wb_o,
  output logic [W_RD-1:0]        wb_r_o,
  output logic [W_OPR-1:0]       result_o
);

  localparam int W_PTR = $clog2(N_REQ);
  // Four bits cover the full MAX_WAIT range of 1..15.
  localparam int W_CNT = 4;
  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(MAX_WAIT);
  localparam logic [W_PTR-1:0] LAST_IDX = W_PTR'(N_REQ - 1);

  logic [W_PTR-1:0] ptr;
  logic [W_CNT-1:0] wait_cnt [N_REQ];

  logic [N_REQ-1:0] aged;
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic [W_PTR-1:0] grant_idx;
  logic [W_PTR-1:0] ptr_next;

  // Grant selection: aged requesters first (lowest index), else round-robin from ptr.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    int idx;
    aged      = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;

    for (int i = 0; i < N_REQ; i++) begin
      aged[i] = req_valid_i[i] && (wait_cnt[i] >= CNT_MAX);
    end

    if (aged != '0) begin
      // Descending scan: the lowest aged index is the last one written.
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (aged[i]) begin
          grant_any = 1'b1;
          grant_idx = W_PTR'(i);
        end
      end
    end else begin
      // Descending offset: the first valid requester at or after ptr wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % N_REQ;
        if (req_valid_i[idx]) begin
          grant_any = 1'b1;
          grant_idx = W_PTR'(idx);
        end
      end
    end

    // No grant during a flush, and ready stays low while reset is held.
    if (flush_i || !rst) begin
      grant_any = 1'b0;
    end

    grant = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign req_ready_o = grant;
  assign ptr_next    = (grant_idx == LAST_IDX) ? '0 : grant_idx + W_PTR'(1);

  // Output register and round-robin pointer; a grant is always a transfer.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      wb_o     <= 1'b0;
      wb_r_o   <= '0;
      result_o <= '0;
    end else begin
      wb_o <= grant_any;
      if (grant_any) begin
        wb_r_o   <= req_rd_i[int'(grant_idx)*W_RD +: W_RD];
        result_o <= req_data_i[int'(grant_idx)*W_OPR +: W_OPR];
        ptr      <= ptr_next;
      end
    end
  end

  // Wait counters: clear when idle or served, otherwise count up to MAX_WAIT.
  // NOTE: the counter array is reset explicitly because it feeds the grant
  // logic; leaving it unknown after reset would corrupt the first grants.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid_i[i] || grant[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] < CNT_MAX) begin
          wait_cnt[i] <= wait_cnt[i] + W_CNT'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with a scoreboard. Each stimulus cycle
// pushes the expected ready vector and, for a grant, the expected write-back
// tagged with the cycle it must appear in; a monitor on the falling edge pops
// and compares. MAX_WAIT is 2 so aging can be exercised in a few cycles.
module tb_wb_arbiter;

  localparam int N_REQ    = 3;
  localparam int W_RD     = 4;
  localparam int W_OPR    = 16;
  localparam int MAX_WAIT = 2;

  typedef struct {
    int               due;
    logic [W_RD-1:0]  rd;
    logic [W_OPR-1:0] data;
  } wb_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic [N_REQ*W_RD-1:0]  req_rd_i;
  logic [N_REQ*W_OPR-1:0] req_data_i;
  logic                   flush_i;
  logic                   wb_o;
  logic [W_RD-1:0]        wb_r_o;
  logic [W_OPR-1:0]       result_o;

  logic [W_RD-1:0]  rd_arr   [N_REQ];
  logic [W_OPR-1:0] data_arr [N_REQ];

  logic [N_REQ-1:0] ready_q [$];
  wb_t              wb_q    [$];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  assign req_rd_i   = {rd_arr[2], rd_arr[1], rd_arr[0]};
  assign req_data_i = {data_arr[2], data_arr[1], data_arr[0]};

  wb_arbiter #(
    .N_REQ   (N_REQ),
    .W_RD    (W_RD),
    .W_OPR   (W_OPR),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_rd_i   (req_rd_i),
    .req_data_i (req_data_i),
    .flush_i    (flush_i),
    .wb_o       (wb_o),
    .wb_r_o     (wb_r_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare ready and write-back against the scoreboard queues.
  always @(negedge clk) begin
    logic [N_REQ-1:0] er;
    wb_t              e;
    if (ready_q.size() > 0) begin
      er = ready_q.pop_front();
      check("ready", 32'(req_ready_o), 32'(er));
    end
    if (wb_o) begin
      if (wb_q.size() == 0) begin
        check("wb_strobe_unexpected", 32'(wb_o), 32'(0));
      end else begin
        e = wb_q.pop_front();
        check("wb_cycle", 32'(cyc), 32'(e.due));
        check("wb_rd", 32'(wb_r_o), 32'(e.rd));
        check("wb_data", 32'(result_o), 32'(e.data));
      end
    end else if (wb_q.size() > 0 && wb_q[0].due <= cyc) begin
      e = wb_q.pop_front();
      check("wb_strobe_missing", 32'(wb_o), 32'(1));
    end
  end

  // One stimulus cycle; entered and left 1 time unit after a rising edge.
  task automatic step(input logic r, input logic [N_REQ-1:0] v, input logic f,
                      input logic [N_REQ-1:0] exp);
    wb_t e;
    rst         = r;
    req_valid_i = v;
    flush_i     = f;
    ready_q.push_back(exp);
    for (int i = 0; i < N_REQ; i++) begin
      if (exp[i]) begin
        e.due  = cyc + 1;
        e.rd   = rd_arr[i];
        e.data = data_arr[i];
        wb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish before time limit");
    $fatal(1);
  end

  initial begin
    rd_arr      = '{4'h1, 4'h2, 4'h3};
    data_arr    = '{16'h1000, 16'h2001, 16'h3002};
    rst         = 1'b0;
    req_valid_i = '0;
    flush_i     = 1'b0;
    @(posedge clk);
    #1;

    // Reset with all requesters valid: no ready, no strobe.
    step(1'b0, 3'b111, 1'b0, 3'b000);
    check("reset_wb", 32'(wb_o), 32'(0));
    step(1'b0, 3'b111, 1'b0, 3'b000);

    // Release: first grant to 0, then round-robin 0,1,2,0,1,2 back to back.
    step(1'b1, 3'b111, 1'b0, 3'b001);
    step(1'b1, 3'b111, 1'b0, 3'b010);
    step(1'b1, 3'b111, 1'b0, 3'b100);
    step(1'b1, 3'b111, 1'b0, 3'b001);
    step(1'b1, 3'b111, 1'b0, 3'b010);
    step(1'b1, 3'b111, 1'b0, 3'b100);
    step(1'b1, 3'b000, 1'b0, 3'b000);

    // Single request from 1: write-back next cycle, strobe low after.
    rd_arr[1]   = 4'h5;
    data_arr[1] = 16'hBEEF;
    step(1'b1, 3'b010, 1'b0, 3'b010);
    step(1'b1, 3'b000, 1'b0, 3'b000);

    // Flush after a transfer: registered write-back survives, ptr unchanged.
    step(1'b1, 3'b001, 1'b0, 3'b001);
    step(1'b1, 3'b101, 1'b1, 3'b000);
    step(1'b1, 3'b101, 1'b0, 3'b100);
    step(1'b1, 3'b001, 1'b0, 3'b001);
    step(1'b1, 3'b000, 1'b0, 3'b000);

    // Aging: bring ptr to 0, hold 2 off with flush, then it beats round-robin.
    step(1'b1, 3'b100, 1'b0, 3'b100);
    step(1'b1, 3'b000, 1'b0, 3'b000);
    step(1'b1, 3'b100, 1'b1, 3'b000);
    step(1'b1, 3'b100, 1'b1, 3'b000);
    step(1'b1, 3'b100, 1'b1, 3'b000);
    step(1'b1, 3'b111, 1'b0, 3'b100);
    step(1'b1, 3'b011, 1'b0, 3'b001);
    step(1'b1, 3'b010, 1'b0, 3'b010);
    step(1'b1, 3'b000, 1'b0, 3'b000);

    // Mid-operation reset: a grant to 1 is registered, then reset drops it.
    rst         = 1'b1;
    req_valid_i = 3'b010;
    flush_i     = 1'b0;
    ready_q.push_back(3'b010);
    @(posedge clk);
    #1;
    check("wb_before_reset", 32'(wb_o), 32'(1));
    rst         = 1'b0;
    req_valid_i = '0;
    #1;
    check("reset_async_wb", 32'(wb_o), 32'(0));
    check("reset_async_rd", 32'(wb_r_o), 32'(0));
    check("reset_async_data", 32'(result_o), 32'(0));
    @(posedge clk);
    #1;

    // After release ptr is 0 again (it was 2 before reset).
    step(1'b1, 3'b111, 1'b0, 3'b001);
    step(1'b1, 3'b110, 1'b0, 3'b010);
    step(1'b1, 3'b100, 1'b0, 3'b100);
    step(1'b1, 3'b000, 1'b0, 3'b000);
    step(1'b1, 3'b000, 1'b0, 3'b000);

    check("sb_ready_q_empty", 32'(ready_q.size()), 32'(0));
    check("sb_wb_q_empty", 32'(wb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
